// File: rtl/module_display_error_scan.sv
// Time-multiplexed N-digit 7-segment driver for SECDED decoder status.
// Digit 0 shows the latched error code; the upper digits show a saturating error count.
module module_display_error_scan #(
  parameter int N_DIGITS    = 4,
  parameter int SYN_W       = 3,
  parameter int REFRESH_DIV = 27000,
  parameter int STICKY      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [SYN_W-1:0]   sindrome,
  input  logic               error_simple,
  input  logic               error_doble,
  input  logic               no_error,
  input  logic               clr,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]         seg
);

  localparam int CNT_W = 4 * (N_DIGITS - 1);
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [3:0]       code_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sticky_q;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;

  logic [3:0] new_code;
  logic       sticky_hold;
  logic       count_hit;

  always_comb begin
    new_code = 4'hF;
    if (error_doble)       new_code = 4'hE;
    else if (error_simple) new_code = 4'(sindrome);
    else if (no_error)     new_code = 4'h0;
  end

  assign sticky_hold = (STICKY != 0) && sticky_q;
  assign count_hit   = error_simple | error_doble;

  // Status capture; clr takes priority over a simultaneous valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= 4'h0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (clr) begin
      code_q   <= 4'h0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (valid) begin
      if (!sticky_hold) code_q <= new_code;
      if ((STICKY != 0) && error_doble) sticky_q <= 1'b1;
      if (count_hit && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Free-running digit scan, unaffected by valid/clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  logic [3:0] nibbles [N_DIGITS];
  logic [3:0] nibble;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_code
      assign nibbles[gi] = code_q;
    end else begin : g_cnt
      assign nibbles[gi] = cnt_q[4*gi-1 -: 4];
    end
    assign an[gi] = (idx_q != IDX_W'(gi));
  end

  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nibble = nibbles[i];
    end
  end

  always_comb begin
    seg = 7'b1000000;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
  end

endmodule

// File: tb/tb_module_display_error_scan.sv
// Bench for the status display: a sticky and a non-sticky instance share stimulus and
// are compared every cycle against a behavioural model, plus literal spot checks.
module tb_module_display_error_scan;

  localparam int N = 4;
  localparam int RD = 4;
  localparam int SW = 3;
  localparam int CMAX = 4095;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0, error_simple = 1'b0, error_doble = 1'b0, no_error = 1'b0, clr = 1'b0;
  logic [SW-1:0] sindrome = '0;
  logic [N-1:0] an_s, an_n;
  logic [6:0] seg_s, seg_n;

  always #5 clk = ~clk;

  module_display_error_scan #(.N_DIGITS(N), .SYN_W(SW), .REFRESH_DIV(RD), .STICKY(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid(valid), .sindrome(sindrome),
    .error_simple(error_simple), .error_doble(error_doble), .no_error(no_error),
    .clr(clr), .an(an_s), .seg(seg_s));

  module_display_error_scan #(.N_DIGITS(N), .SYN_W(SW), .REFRESH_DIV(RD), .STICKY(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .valid(valid), .sindrome(sindrome),
    .error_simple(error_simple), .error_doble(error_doble), .no_error(no_error),
    .clr(clr), .an(an_n), .seg(seg_n));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: index 0 = sticky instance, 1 = non-sticky instance.
  int t;
  int m_code [2];
  int m_cnt  [2];
  bit m_sticky [2];

  function automatic int code_of(input bit es, input bit ed, input bit ne, input int s);
    if (ed) return 14;
    if (es) return s;
    if (ne) return 0;
    return 15;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0;
      for (int m = 0; m < 2; m++) begin
        m_code[m] <= 0; m_cnt[m] <= 0; m_sticky[m] <= 1'b0;
      end
    end else begin
      t <= t + 1;
      for (int m = 0; m < 2; m++) begin
        if (clr) begin
          m_code[m] <= 0; m_cnt[m] <= 0; m_sticky[m] <= 1'b0;
        end else if (valid) begin
          if (!(m == 0 && m_sticky[m]))
            m_code[m] <= code_of(error_simple, error_doble, no_error, int'(sindrome));
          if (m == 0 && error_doble) m_sticky[m] <= 1'b1;
          if (error_simple || error_doble)
            m_cnt[m] <= (m_cnt[m] < CMAX) ? m_cnt[m] + 1 : CMAX;
        end
      end
    end
  end

  function automatic logic [6:0] font(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  function automatic int cur_digit();
    return (t / RD) % N;
  endfunction

  function automatic logic [6:0] exp_seg(input int m);
    int d;
    d = cur_digit();
    if (d == 0) return font(m_code[m]);
    return font((m_cnt[m] >> (4 * (d - 1))) & 15);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("an_sticky", 32'(an_s), 32'(4'b1111 & ~(4'b0001 << cur_digit())));
      check("an_plain",  32'(an_n), 32'(4'b1111 & ~(4'b0001 << cur_digit())));
      check("seg_sticky", 32'(seg_s), 32'(exp_seg(0)));
      check("seg_plain",  32'(seg_n), 32'(exp_seg(1)));
    end
  end

  task automatic wait_digit(input int d);
    int n;
    n = 0;
    while (cur_digit() != d && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("wait_digit_timeout", 32'(n), 32'(0));
  endtask

  task automatic strobe(input bit v, input bit es, input bit ed, input bit ne,
                        input logic [SW-1:0] s, input bit c);
    valid = v; error_simple = es; error_doble = ed; no_error = ne; sindrome = s; clr = c;
    @(negedge clk);
    valid = 0; error_simple = 0; error_doble = 0; no_error = 0; sindrome = '0; clr = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_an", 32'(an_s), 32'(4'b1110));
    check("reset_seg", 32'(seg_s), 32'(7'b1000000));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan across all digits.
    repeat (16) @(negedge clk);

    strobe(1, 1, 0, 0, 3'd5, 0);
    wait_digit(0);
    check("single_code5", 32'(seg_s), 32'(7'b0010010));
    wait_digit(1);
    check("single_cnt1", 32'(seg_s), 32'(7'b1111001));

    strobe(0, 0, 0, 0, 3'd0, 1);
    strobe(1, 0, 1, 0, 3'd0, 0);
    strobe(1, 1, 0, 0, 3'd3, 0);
    wait_digit(0);
    check("sticky_holds_E", 32'(seg_s), 32'(7'b0000110));
    check("plain_shows_3", 32'(seg_n), 32'(7'b0110000));
    wait_digit(1);
    check("sticky_cnt2", 32'(seg_s), 32'(7'b0100100));
    strobe(0, 0, 0, 0, 3'd0, 1);
    wait_digit(0);
    check("clr_code0", 32'(seg_s), 32'(7'b1000000));
    wait_digit(1);
    check("clr_cnt0", 32'(seg_s), 32'(7'b1000000));

    strobe(1, 0, 0, 0, 3'd0, 0);
    wait_digit(0);
    check("undef_F", 32'(seg_s), 32'(7'b0001110));
    strobe(1, 1, 0, 0, 3'd6, 1);
    wait_digit(0);
    check("clr_beats_valid_code", 32'(seg_s), 32'(7'b1000000));
    wait_digit(1);
    check("clr_beats_valid_cnt", 32'(seg_s), 32'(7'b1000000));

    // Randomised traffic.
    repeat (400) begin
      valid = $urandom_range(0, 1);
      error_simple = $urandom_range(0, 1);
      error_doble = ($urandom_range(0, 3) == 0);
      no_error = $urandom_range(0, 1);
      sindrome = 3'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    valid = 0; error_simple = 0; error_doble = 0; no_error = 0; clr = 0;

    // Saturation of the count.
    strobe(0, 0, 0, 0, 3'd0, 1);
    valid = 1; error_simple = 1; sindrome = 3'd1;
    repeat (4200) @(negedge clk);
    valid = 0; error_simple = 0;
    for (int d = 1; d < N; d++) begin
      wait_digit(d);
      check("sat_digit_F", 32'(seg_s), 32'(7'b0001110));
    end

    // Asynchronous reset mid-scan.
    wait_digit(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an_s), 32'(4'b1110));
    check("async_rst_seg", 32'(seg_s), 32'(7'b1000000));
    check("async_rst_seg_plain", 32'(seg_n), 32'(7'b1000000));
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
